// File: rtl/hwa_total.sv
// Stochastic-computing multiply/accumulate over a 2^N-cycle window.
// One input probability is multiplied by CH fixed weights; counts land on out at window end.
module hwa_total #(
  parameter int unsigned N  = 12,
  parameter int unsigned CH = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [N:0]            in,
  output logic [CH*(N+1)-1:0]   out
);

  localparam int unsigned W = N + 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state, state_nx;
  logic [N-1:0]    idx, idx_nx, rx;
  logic [W-1:0]    acc    [CH];
  logic [W-1:0]    acc_nx [CH];
  logic [CH*W-1:0] out_nx;
  logic            x;
  logic [CH-1:0]   p;

  // Channel k weight is (CH-k)/CH of full scale: 4096, 3072, 2048, 1024 for the defaults.
  function automatic logic [W-1:0] weight(input int unsigned k);
    return W'(((CH - k) << N) / CH);
  endfunction

  // Input and weight stochastic bits from the shared window index.
  always_comb begin
    rx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      rx[i] = idx[N-1-i];
    end
    x = (in > {1'b0, rx});
    p = '0;
    for (int unsigned k = 0; k < CH; k++) begin
      p[k] = x & (weight(k) > {1'b0, idx});
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    out_nx   = out;
    for (int unsigned k = 0; k < CH; k++) begin
      acc_nx[k] = acc[k];
    end
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = RUN;
          idx_nx   = '0;
          for (int unsigned k = 0; k < CH; k++) begin
            acc_nx[k] = '0;
          end
        end
      end
      RUN: begin
        idx_nx = idx + N'(1);
        for (int unsigned k = 0; k < CH; k++) begin
          acc_nx[k] = acc[k] + W'(p[k]);
        end
        if (idx == '1) begin
          state_nx = IDLE;
          for (int unsigned k = 0; k < CH; k++) begin
            out_nx[k*W +: W] = acc[k] + W'(p[k]);
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
      idx   <= '0;
      out   <= '0;
      for (int unsigned k = 0; k < CH; k++) begin
        acc[k] <= '0;
      end
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      out   <= out_nx;
      for (int unsigned k = 0; k < CH; k++) begin
        acc[k] <= acc_nx[k];
      end
    end
  end

endmodule

// File: tb/tb_hwa_total.sv
// Randomized bench for hwa_total with a per-window stochastic-count reference model.
module tb_hwa_total;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic [12:0] in_v;
  logic [51:0] out;

  int n_cmp;
  int n_bad;
  int prev [4];

  hwa_total dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .in      (in_v),
    .out     (out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input int got, input int expv);
    n_cmp++;
    if (got != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, expv);
    end
  endtask

  function automatic int chan(input int k);
    logic [12:0] v;
    v = out[13*k +: 13];
    return int'(v);
  endfunction

  function automatic int bitrev12(input int j);
    int r;
    r = 0;
    for (int i = 0; i < 12; i++) begin
      if (((j >> i) & 1) != 0) r = r | (1 << (11 - i));
    end
    return r;
  endfunction

  task automatic check_all(input string tag, input int e0, input int e1, input int e2, input int e3);
    check_eq({tag, "_ch0"}, chan(0), e0);
    check_eq({tag, "_ch1"}, chan(1), e1);
    check_eq({tag, "_ch2"}, chan(2), e2);
    check_eq({tag, "_ch3"}, chan(3), e3);
  endtask

  function automatic int pick_in(input int kind, input int cval);
    int r;
    if (kind == 0) return cval;
    r = int'($urandom_range(0, 9));
    if (r == 0) return 0;
    if (r == 1) return 4096;
    return int'($urandom_range(0, 4096));
  endfunction

  // Caller sits at a negedge; the window is requested immediately so windows can be back-to-back.
  task automatic run_window(input string tag, input int kind, input int cval, input bit extra);
    int expc [4];
    int v;
    int wt;
    for (int k = 0; k < 4; k++) expc[k] = 0;
    start = 1'b1;
    @(negedge clock);
    for (int j = 0; j < 4096; j++) begin
      v     = pick_in(kind, cval);
      in_v  = 13'(v);
      start = (extra && (j == 100 || j == 2000)) ? 1'b1 : 1'b0;
      for (int k = 0; k < 4; k++) begin
        wt = 4096 - 1024 * k;
        if (v > bitrev12(j) && wt > j) expc[k]++;
      end
      if (j == 4095) check_all({tag, "_hold"}, prev[0], prev[1], prev[2], prev[3]);
      @(negedge clock);
    end
    start = 1'b0;
    check_all(tag, expc[0], expc[1], expc[2], expc[3]);
    for (int k = 0; k < 4; k++) prev[k] = expc[k];
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    reset_n = 1'b0;
    start   = 1'b1;
    in_v    = 13'd4096;
    for (int k = 0; k < 4; k++) prev[k] = 0;

    // Reset with start held high must still leave the block idle.
    repeat (2) @(negedge clock);
    check_all("reset", 0, 0, 0, 0);
    reset_n = 1'b1;
    start   = 1'b0;
    for (int c = 1; c <= 5000; c++) begin
      in_v = 13'($urandom_range(0, 4096));
      @(negedge clock);
      if (c % 1000 == 0) check_eq("idle_after_reset", chan(c / 1000 % 4), 0);
    end

    run_window("full", 0, 4096, 1'b0);
    check_all("full_const", 4096, 3072, 2048, 1024);
    run_window("zero", 0, 0, 1'b0);
    check_all("zero_const", 0, 0, 0, 0);
    run_window("small", 0, 3, 1'b0);
    check_all("small_const", 3, 3, 2, 1);

    repeat (7) @(negedge clock);
    check_all("idle_hold", 3, 3, 2, 1);

    run_window("extra_start", 0, 4096, 1'b1);
    check_all("extra_const", 4096, 3072, 2048, 1024);

    for (int r = 0; r < 3; r++) begin
      run_window($sformatf("rand%0d", r), 1, 0, 1'b0);
    end

    // Abort a window part way through with reset.
    start = 1'b1;
    in_v  = 13'd4096;
    @(negedge clock);
    start = 1'b0;
    repeat (1000) @(negedge clock);
    check_eq("pre_abort_hold", chan(0), prev[0]);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    check_all("abort", 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) prev[k] = 0;
    repeat (10) @(negedge clock);
    check_all("abort_idle", 0, 0, 0, 0);
    run_window("after_abort", 0, 4096, 1'b0);
    check_all("after_abort_const", 4096, 3072, 2048, 1024);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
